// File: rtl/sdram_write_seg.sv
// sdram_write_seg: SDRAM write-burst engine that splits one request of any length
// into per-page segments (ACT / WRITE / burst / BT / tWR / PRE / tRP), moving to the
// next row (and next bank on row wrap) at each column-page boundary.
//
// Ports:
//   sys_clk_i, rst_n_i          clock; synchronous active-low reset
//   init_end_i                  SDRAM init done, gates request acceptance only
//   wr_en_i                     write request level, held until wr_end_o
//   wr_addr_i                   {bank,row,col} start address
//   wr_data_i                   write data, consumed every cycle wr_ack_o=1
//   wr_burst_len_i              words to write; 0 means ignore the request
//   wr_ack_o                    data-consume strobe (same as wr_sdram_en_o)
//   wr_end_o                    one-cycle completion pulse
//   wr_busy_o                   high whenever the engine is not idle
//   write_cmd_o                 registered {CS_n,RAS_n,CAS_n,WE_n}
//   write_ba_o, write_addr_o    registered bank / A-bus
//   wr_sdram_en_o               DQ output enable
//   wr_sdram_data_o             DQ data, zero when not enabled
module sdram_write_seg #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BA_W   = 2,
    parameter int unsigned ROW_W  = 13,
    parameter int unsigned COL_W  = 9,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned TRCD   = 2,
    parameter int unsigned TWR    = 2,
    parameter int unsigned TRP    = 2
) (
    input  logic                          sys_clk_i,
    input  logic                          rst_n_i,
    input  logic                          init_end_i,
    input  logic                          wr_en_i,
    input  logic [BA_W+ROW_W+COL_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    input  logic [LEN_W-1:0]              wr_burst_len_i,
    output logic                          wr_ack_o,
    output logic                          wr_end_o,
    output logic                          wr_busy_o,
    output logic [3:0]                    write_cmd_o,
    output logic [BA_W-1:0]               write_ba_o,
    output logic [ADDR_W-1:0]             write_addr_o,
    output logic                          wr_sdram_en_o,
    output logic [DATA_W-1:0]             wr_sdram_data_o
);

    localparam int unsigned WADDR_W = BA_W + ROW_W + COL_W;
    localparam int unsigned SEG_W   = COL_W + 1;
    localparam int unsigned CNT_W   = (SEG_W > 16) ? SEG_W : 16;
    localparam int unsigned CMP_W   = (LEN_W > SEG_W) ? LEN_W : SEG_W;
    localparam int unsigned PAGE    = 2 ** COL_W;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_BT   = 4'b0110;
    localparam logic [3:0] CMD_PRE  = 4'b0010;

    // A-bus pattern for precharge-all: only A10 set
    localparam logic [ADDR_W-1:0] A10_ONLY = ADDR_W'(1) << 10;

    typedef enum logic [3:0] {
        S_IDLE, S_ACT, S_TRCD, S_WRITE, S_DATA, S_TWR, S_PRE, S_TRP, S_END
    } state_t;

    state_t              cur_state;
    state_t              nxt_state;
    logic [CNT_W-1:0]    cnt;
    logic [BA_W-1:0]     bank;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    col;
    logic [LEN_W-1:0]    remaining;
    logic [SEG_W-1:0]    seg;

    logic                start_c;
    logic                data_last_c;
    logic [SEG_W-1:0]    room_c;
    logic [SEG_W-1:0]    seg_c;
    logic [3:0]          cmd_nxt;
    logic [BA_W-1:0]     ba_nxt;
    logic [ADDR_W-1:0]   addr_nxt;

    assign start_c     = wr_en_i & init_end_i & (wr_burst_len_i != '0);
    assign data_last_c = (cnt == CNT_W'(seg) - CNT_W'(1));

    // Segment length: the lesser of words still owed and words left in this page
    assign room_c = SEG_W'(PAGE) - SEG_W'(col);
    assign seg_c  = (CMP_W'(remaining) < CMP_W'(room_c)) ? SEG_W'(remaining) : room_c;

    // State register
    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE:  if (start_c) nxt_state = S_ACT;
            S_ACT:   nxt_state = S_TRCD;
            S_TRCD:  if (cnt == CNT_W'(TRCD - 1)) nxt_state = S_WRITE;
            S_WRITE: nxt_state = S_DATA;
            S_DATA:  if (data_last_c) nxt_state = S_TWR;
            S_TWR:   if (cnt == CNT_W'(TWR - 1)) nxt_state = S_PRE;
            S_PRE:   nxt_state = S_TRP;
            S_TRP:   if (cnt == CNT_W'(TRP - 1)) nxt_state = (remaining != '0) ? S_ACT : S_END;
            S_END:   nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // Output decode: status/DQ are combinational, command fields feed the bus register
    always_comb begin
        cmd_nxt         = CMD_NOP;
        ba_nxt          = '1;
        addr_nxt        = '1;
        wr_ack_o        = (cur_state == S_DATA);
        wr_sdram_en_o   = (cur_state == S_DATA);
        wr_end_o        = (cur_state == S_END);
        wr_busy_o       = (cur_state != S_IDLE);
        wr_sdram_data_o = (cur_state == S_DATA) ? wr_data_i : '0;
        case (cur_state)
            S_ACT: begin
                cmd_nxt  = CMD_ACT;
                ba_nxt   = bank;
                addr_nxt = ADDR_W'(row);
            end
            S_WRITE: begin
                cmd_nxt  = CMD_WR;
                ba_nxt   = bank;
                addr_nxt = ADDR_W'(col);
            end
            S_DATA: begin
                if (data_last_c) cmd_nxt = CMD_BT;
            end
            S_PRE: begin
                cmd_nxt  = CMD_PRE;
                ba_nxt   = bank;
                addr_nxt = A10_ONLY;
            end
            default: ;
        endcase
    end

    // Command bus register: command for a state appears one cycle after it
    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            write_cmd_o  <= CMD_NOP;
            write_ba_o   <= '1;
            write_addr_o <= '1;
        end else begin
            write_cmd_o  <= cmd_nxt;
            write_ba_o   <= ba_nxt;
            write_addr_o <= addr_nxt;
        end
    end

    // Shared wait/burst counter: restarts on every state change
    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (cur_state == S_IDLE || nxt_state != cur_state) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Request address/length tracking across segments
    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            bank      <= '0;
            row       <= '0;
            col       <= '0;
            remaining <= '0;
            seg       <= '0;
        end else begin
            case (cur_state)
                S_IDLE: begin
                    if (start_c) begin
                        bank      <= wr_addr_i[WADDR_W-1 -: BA_W];
                        row       <= wr_addr_i[COL_W +: ROW_W];
                        col       <= wr_addr_i[COL_W-1:0];
                        remaining <= wr_burst_len_i;
                    end
                end
                S_WRITE: seg <= seg_c;
                S_DATA: begin
                    if (data_last_c) remaining <= remaining - LEN_W'(seg);
                end
                S_TRP: begin
                    // Continuation starts at column 0 of the next row; row wrap carries into bank
                    if (cnt == CNT_W'(TRP - 1) && remaining != '0) begin
                        col <= '0;
                        row <= row + ROW_W'(1);
                        if (&row) bank <= bank + BA_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
